// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, display-enable and lock status from raw VGA sync inputs.
// Define VGA_SYNC_DEC_ERRCNT_EN to add the saturating err_cnt output.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_BP        = 29,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_n,
  input  logic       vsync_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       de,
  output logic       locked,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       err
`ifdef VGA_SYNC_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
);
`else
);
`endif

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [9:0] HBP      = 10'(H_BP);
  localparam logic [9:0] HEND     = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0] VBP      = 10'(V_BP);
  localparam logic [9:0] VEND     = 10'(V_BP + V_ACTIVE);
  localparam logic [9:0] CNT_MAX  = 10'h3FF;
  localparam logic [7:0] LOCK_CNT = 8'(LOCK_FRAMES);

  state_e     state_q, state_d;
  logic       hsPrev_q, vsPrev_q;
  logic       hsRise, vsRise;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       vsSeen_q, vsSeen_d;
  logic       hSeen_q, hSeen_d;
  logic [9:0] hTotal_q, hTotal_d;
  logic [9:0] vTotal_q, vTotal_d;
  logic [9:0] prevH_q, prevH_d;
  logic [9:0] prevV_q, prevV_d;
  logic [7:0] matchCnt_q, matchCnt_d;
  logic       timeout, frameMatch, lossOfLock, deNext;
  logic       de_q, frameStart_q, err_q;
  logic [9:0] pixX_q, pixY_q;

  // vsSeen remembers a vsync edge until the next hsync edge restarts the line count
  always_comb begin
    hsRise   = hsync_n & ~hsPrev_q;
    vsRise   = vsync_n & ~vsPrev_q;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    vsSeen_d = vsSeen_q | vsRise;
    if (hsRise) begin
      hcnt_d   = '0;
      vsSeen_d = 1'b0;
      if (vsSeen_q || vsRise) vcnt_d = '0;
      else if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end
    hTotal_d   = (hsRise && hSeen_q) ? hcnt_q + 10'd1 : hTotal_q;
    vTotal_d   = vsRise ? vcnt_q + 10'd1 : vTotal_q;
    timeout    = (hcnt_d == CNT_MAX);
    frameMatch = (hTotal_d == prevH_q) && (vTotal_d == prevV_q);
  end

  // A zero match count means no reference frame yet, so the first frame only seeds it
  always_comb begin
    matchCnt_d = matchCnt_q;
    prevH_d    = prevH_q;
    prevV_d    = prevV_q;
    if (vsRise) begin
      if (state_q == SEARCH) begin
        matchCnt_d = '0;
      end else begin
        prevH_d = hTotal_d;
        prevV_d = vTotal_d;
        if (state_q == MEASURE) begin
          if (matchCnt_q == '0) matchCnt_d = 8'd1;
          else if (frameMatch) matchCnt_d = matchCnt_q + 8'd1;
          else matchCnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vsRise) state_d = MEASURE;
      MEASURE: begin
        if (timeout) state_d = SEARCH;
        else if (vsRise && matchCnt_d == LOCK_CNT) state_d = LOCKED;
      end
      LOCKED:  if (timeout || (vsRise && !frameMatch)) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    lossOfLock = (state_q == LOCKED) && (state_d == SEARCH);
    hSeen_d    = hSeen_q;
    if (state_q != SEARCH && state_d == SEARCH) hSeen_d = 1'b0;
    else if (hsRise) hSeen_d = 1'b1;
    deNext = locked && (hcnt_q >= HBP) && (hcnt_q < HEND) && (vcnt_q >= VBP) && (vcnt_q < VEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hsPrev_q     <= 1'b1;
      vsPrev_q     <= 1'b1;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vsSeen_q     <= 1'b0;
      hSeen_q      <= 1'b0;
      hTotal_q     <= '0;
      vTotal_q     <= '0;
      prevH_q      <= '0;
      prevV_q      <= '0;
      matchCnt_q   <= '0;
      de_q         <= 1'b0;
      pixX_q       <= '0;
      pixY_q       <= '0;
      frameStart_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hsPrev_q     <= hsync_n;
      vsPrev_q     <= vsync_n;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vsSeen_q     <= vsSeen_d;
      hSeen_q      <= hSeen_d;
      hTotal_q     <= hTotal_d;
      vTotal_q     <= vTotal_d;
      prevH_q      <= prevH_d;
      prevV_q      <= prevV_d;
      matchCnt_q   <= matchCnt_d;
      de_q         <= deNext;
      pixX_q       <= deNext ? hcnt_q - HBP : '0;
      pixY_q       <= deNext ? vcnt_q - VBP : '0;
      frameStart_q <= vsRise;
      err_q        <= lossOfLock;
    end
  end

`ifdef VGA_SYNC_DEC_ERRCNT_EN
  logic [7:0] errCnt_q;

  always_ff @(posedge clk) begin
    if (reset) errCnt_q <= '0;
    else if (lossOfLock && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
  end

  assign err_cnt = errCnt_q;
`endif

  assign pix_x       = pixX_q;
  assign pix_y       = pixY_q;
  assign de          = de_q;
  assign frame_start = frameStart_q;
  assign h_total     = hTotal_q;
  assign v_total     = vTotal_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken raster: 40-clock lines with a
// 6-clock hsync pulse, 20-line frames with vsync low for lines 0-1.
module tb_vga_sync_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_n = 1'b1;
  logic       vsync_n = 1'b1;
  logic [9:0] pix_x, pix_y, h_total, v_total;
  logic       de, locked, frame_start, err;
`ifdef VGA_SYNC_DEC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  vga_sync_decoder #(
    .H_ACTIVE(24), .H_BP(4), .V_ACTIVE(12), .V_BP(3), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .pix_x(pix_x), .pix_y(pix_y), .de(de), .locked(locked),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .err(err)
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic h, input logic v);
    @(negedge clk);
    hsync_n = h;
    vsync_n = v;
  endtask

  // vsC is the clock within line 2 at which vsync_n returns high
  task automatic driveClk(input int line, input int c, input int vsC);
    logic h, v;
    h = (c >= 6) ? 1'b1 : 1'b0;
    v = (line < 2 || (line == 2 && c < vsC)) ? 1'b0 : 1'b1;
    applyStimulus(h, v);
  endtask

  task automatic runLine(input int line, input int fromC, input int len, input int vsC);
    for (int c = fromC; c < len; c++) driveClk(line, c, vsC);
  endtask

  task automatic runFrame();
    for (int l = 0; l < 20; l++) runLine(l, 0, 40, 0);
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    testsRun++; if (de !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_de: got %b want 0", de); end
    testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    testsRun++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_pix: got %0d,%0d want 0,0", pix_x, pix_y); end
    testsRun++; if (h_total !== 10'd0 || v_total !== 10'd0) begin testsFailed++; $display("[TB] FAIL reset_totals: got %0d,%0d want 0,0", h_total, v_total); end
    testsRun++; if (frame_start !== 1'b0 || err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pulses: got fs=%b err=%b want 0,0", frame_start, err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock();
    runFrame();
    runFrame();
    testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL lock_early: got %b want 0", locked); end
    testsRun++; if (h_total !== 10'd40) begin testsFailed++; $display("[TB] FAIL lock_h_total: got %0d want 40", h_total); end
    testsRun++; if (v_total !== 10'd20) begin testsFailed++; $display("[TB] FAIL lock_v_total: got %0d want 20", v_total); end
    runLine(0, 0, 40, 0);
    runLine(1, 0, 40, 0);
    testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL lock_before_third: got %b want 0", locked); end
    driveClk(2, 0, 0);
    sampleAfterEdge();
    testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL lock_third_edge: got %b want 1", locked); end
    testsRun++; if (frame_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL frame_start_pulse: got %b want 1", frame_start); end
    driveClk(2, 1, 0);
    sampleAfterEdge();
    testsRun++; if (frame_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL frame_start_width: got %b want 0", frame_start); end
  endtask

  // Active window: lines 5..16, clocks 11..34 of the driven line
  task automatic test_de_window();
    logic       expDe;
    logic [9:0] expX, expY;
    for (int l = 2; l < 20; l++) begin
      for (int c = (l == 2) ? 2 : 0; c < 40; c++) begin
        driveClk(l, c, 0);
        sampleAfterEdge();
        expDe = (l >= 5 && l <= 16 && c >= 11 && c <= 34);
        expX  = expDe ? 10'(c - 11) : 10'd0;
        expY  = expDe ? 10'(l - 5) : 10'd0;
        testsRun++;
        if ({de, pix_x, pix_y} !== {expDe, expX, expY}) begin
          testsFailed++;
          $display("[TB] FAIL de_window line %0d clk %0d: got de=%b x=%0d y=%0d want de=%b x=%0d y=%0d",
                   l, c, de, pix_x, pix_y, expDe, expX, expY);
        end
      end
    end
  endtask

  task automatic test_line_error();
    runLine(0, 0, 41, 0);
    runLine(1, 0, 40, 0);
    driveClk(2, 0, 0);
    sampleAfterEdge();
    testsRun++; if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL line_err_pulse: got %b want 1", err); end
    testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL line_err_locked: got %b want 0", locked); end
    testsRun++; if (h_total !== 10'd41) begin testsFailed++; $display("[TB] FAIL line_err_h_total: got %0d want 41", h_total); end
    driveClk(2, 1, 0);
    sampleAfterEdge();
    testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL line_err_width: got %b want 0", err); end
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    testsRun++; if (err_cnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL err_cnt_one: got %0d want 1", err_cnt); end
`endif
    runLine(2, 2, 40, 0);
    for (int l = 3; l < 20; l++) runLine(l, 0, 40, 0);
  endtask

  task automatic test_timeout();
    int errPulses = 0;
    int errAt = -1;
    runFrame();
    runFrame();
    for (int l = 0; l < 8; l++) runLine(l, 0, 40, 0);
    testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL relock_after_error: got %b want 1", locked); end
    runLine(8, 0, 6, 0);
    for (int i = 0; i < 1100; i++) begin
      applyStimulus(1'b1, 1'b1);
      sampleAfterEdge();
      if (err === 1'b1) begin
        errPulses++;
        errAt = i;
      end
    end
    testsRun++; if (errPulses != 1) begin testsFailed++; $display("[TB] FAIL timeout_err_count: got %0d want 1", errPulses); end
    testsRun++; if (errAt != 1023) begin testsFailed++; $display("[TB] FAIL timeout_err_clock: got %0d want 1023", errAt); end
    testsRun++; if (locked !== 1'b0 || de !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_state: got locked=%b de=%b want 0,0", locked, de); end
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    testsRun++; if (err_cnt !== 8'd2) begin testsFailed++; $display("[TB] FAIL err_cnt_two: got %0d want 2", err_cnt); end
`endif
  endtask

  task automatic test_reset_midline();
    runFrame();
    runFrame();
    for (int l = 0; l < 8; l++) runLine(l, 0, 40, 0);
    runLine(8, 0, 21, 0);
    sampleAfterEdge();
    testsRun++; if (de !== 1'b1 || pix_x !== 10'd9 || pix_y !== 10'd3) begin testsFailed++; $display("[TB] FAIL midline_active: got de=%b x=%0d y=%0d want 1,9,3", de, pix_x, pix_y); end
    driveClk(8, 21, 0);
    reset = 1'b1;
    sampleAfterEdge();
    testsRun++; if (de !== 1'b0 || locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL midline_reset_flags: got de=%b locked=%b want 0,0", de, locked); end
    testsRun++; if (pix_x !== 10'd0 || h_total !== 10'd0) begin testsFailed++; $display("[TB] FAIL midline_reset_values: got x=%0d h_total=%0d want 0,0", pix_x, h_total); end
`ifdef VGA_SYNC_DEC_ERRCNT_EN
    testsRun++; if (err_cnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL err_cnt_reset: got %0d want 0", err_cnt); end
`endif
    driveClk(8, 22, 0);
    reset = 1'b0;
    runLine(8, 23, 40, 0);
    for (int l = 9; l < 20; l++) runLine(l, 0, 40, 0);
    runFrame();
    runFrame();
    runLine(0, 0, 40, 0);
    runLine(1, 0, 40, 0);
    testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL relock_early: got %b want 0", locked); end
    driveClk(2, 0, 0);
    sampleAfterEdge();
    testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL relock_third_edge: got %b want 1", locked); end
    testsRun++; if (h_total !== 10'd40 || v_total !== 10'd20) begin testsFailed++; $display("[TB] FAIL relock_totals: got %0d,%0d want 40,20", h_total, v_total); end
  endtask

  // vsync_n and hsync_n rise together on line 2; line 2 must still become row count 0
  task automatic test_simultaneous_edges();
    runLine(2, 1, 40, 0);
    for (int l = 3; l < 20; l++) runLine(l, 0, 40, 0);
    runLine(0, 0, 40, 6);
    runLine(1, 0, 40, 6);
    runLine(2, 0, 6, 6);
    driveClk(2, 6, 6);
    sampleAfterEdge();
    testsRun++; if (frame_start !== 1'b1 || locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL simul_edge: got fs=%b locked=%b want 1,1", frame_start, locked); end
    runLine(2, 7, 40, 6);
    runLine(3, 0, 40, 6);
    runLine(4, 0, 40, 6);
    runLine(5, 0, 11, 6);
    driveClk(5, 11, 6);
    sampleAfterEdge();
    testsRun++; if (de !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin testsFailed++; $display("[TB] FAIL simul_first_pixel: got de=%b x=%0d y=%0d want 1,0,0", de, pix_x, pix_y); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_de_window();
    test_line_error();
    test_timeout();
    test_reset_midline();
    test_simultaneous_edges();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
